// File: rtl/icache_line_refill_if.sv
// Fetch-side and refill-side signal bundle for icache_line_refill.
// master drives requests and memory responses; slave is the cache.
interface icache_line_refill_if #(
    parameter int ADDR_W = 18
);
    logic              rdy;
    logic              flush_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_valid_o;
    logic [31:0]       if_inst_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_valid_i;
    logic [7:0]        mem_data_i;

    modport master (
        output rdy, flush_i, if_req_i, if_addr_i, mem_valid_i, mem_data_i,
        input  if_valid_o, if_inst_o, mem_req_o, mem_addr_o
    );

    modport slave (
        input  rdy, flush_i, if_req_i, if_addr_i, mem_valid_i, mem_data_i,
        output if_valid_o, if_inst_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/icache_line_refill.sv
// Direct-mapped instruction cache; misses refill a whole line byte-by-byte, then the fetch hits.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_line_refill #(
    parameter int ADDR_W     = 18,
    parameter int LINE_NUM   = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    icache_line_refill_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
`endif
);
    localparam int LINE_BYTES = 4 * LINE_WORDS;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int IDX_W      = $clog2(LINE_NUM);
    localparam int TAG_W      = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W     = 8 * LINE_BYTES;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REFILL  = 2'd1;
    localparam logic [1:0] ST_INSTALL = 2'd2;

    localparam logic [OFF_W-1:0] LAST_BYTE = OFF_W'(LINE_BYTES - 1);

    logic [1:0]              state;
    logic [OFF_W-1:0]        cnt;
    logic [ADDR_W-OFF_W-1:0] base;
    logic [LINE_NUM-1:0]     valid;
    logic [TAG_W-1:0]        tag_mem  [LINE_NUM];
    logic [LINE_W-1:0]       data_mem [LINE_NUM];
    logic [LINE_W-1:0]       line_buf;

    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        req_idx;
    logic [OFF_W-1:0]        req_off;
    logic [TAG_W-1:0]        base_tag;
    logic [IDX_W-1:0]        base_idx;

    assign {req_tag, req_idx, req_off} = bus.if_addr_i;
    assign {base_tag, base_idx}        = base;

    logic              lookup_hit;
    logic              hit;
    logic              miss_start;
    logic              byte_take;
    logic              install;
    logic [OFF_W-1:0]  word_off;
    logic [LINE_W-1:0] hit_line;

    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign hit        = rst && bus.rdy && bus.if_req_i && (state == ST_IDLE) && lookup_hit;
    // flush_i outranks both a new miss and the install write in the same cycle.
    assign miss_start = rst && bus.rdy && !bus.flush_i && bus.if_req_i
                        && (state == ST_IDLE) && !lookup_hit;
    assign byte_take  = rst && bus.rdy && !bus.flush_i && (state == ST_REFILL) && bus.mem_valid_i;
    assign install    = rst && bus.rdy && !bus.flush_i && (state == ST_INSTALL);

    assign word_off = req_off & ~OFF_W'(3);
    assign hit_line = data_mem[req_idx];

    assign bus.if_valid_o = hit;
    assign bus.if_inst_o  = hit ? hit_line[{word_off, 3'b000} +: 32] : 32'd0;
    assign bus.mem_req_o  = rst && (state == ST_REFILL);
    assign bus.mem_addr_o = bus.mem_req_o ? {base, cnt} : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            valid <= '0;
        end else if (bus.rdy) begin
            if (bus.flush_i) begin
                valid <= '0;
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (miss_start) begin
                            state <= ST_REFILL;
                            cnt   <= '0;
                        end
                    end
                    ST_REFILL: begin
                        if (bus.mem_valid_i) begin
                            // The counter parks on the last byte; it only restarts on the next miss.
                            if (cnt == LAST_BYTE) begin
                                state <= ST_INSTALL;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_INSTALL: begin
                        valid[base_idx] <= 1'b1;
                        state           <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: tag/data storage and the line buffer have no reset; valid bits decide whether contents are used.
    always_ff @(posedge clk) begin
        if (miss_start) begin
            base <= bus.if_addr_i[ADDR_W-1:OFF_W];
        end
        if (byte_take) begin
            line_buf[{cnt, 3'b000} +: 8] <= bus.mem_data_i;
        end
        if (install) begin
            data_mem[base_idx] <= line_buf;
            tag_mem[base_idx]  <= base_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (bus.rdy) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_line_refill.sv
// Scoreboard bench for icache_line_refill: a line-level cache model predicts refill addresses
// and returned words; a negedge monitor pops and compares whatever the DUT presents.
module tb_icache_line_refill;
    localparam int ADDR_W = 18;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icache_line_refill_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_line_refill #(.ADDR_W(ADDR_W), .LINE_NUM(64), .LINE_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]        mem_img [0:(1<<ADDR_W)-1];
    bit                m_valid [64];
    logic [7:0]        m_tag   [64];
    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [31:0]       exp_inst_q [$];

    int gap_mode   = 0;   // 0: byte every cycle, 1: every other cycle, 2: random
    int rdy_mode   = 0;   // 0: ready, 1: one directed 3-cycle stall, 2: random
    int stall_trig = -1;
    int stall_left = 0;
    int acc_cnt    = 0;
    bit tog        = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name, input logic [31:0] info);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event (0x%08h) expected none at %0t", name, info, $time);
    endtask

    function automatic int m_idx(input logic [ADDR_W-1:0] a);
        return (int'(a) >> 4) & 63;
    endfunction

    function automatic logic [7:0] m_tagof(input logic [ADDR_W-1:0] a);
        return 8'(int'(a) >> 10);
    endfunction

    function automatic logic [31:0] model_word(input logic [ADDR_W-1:0] a);
        int w;
        w = int'(a) & ~3;
        return {mem_img[w+3], mem_img[w+2], mem_img[w+1], mem_img[w]};
    endfunction

    task automatic model_invalidate();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        exp_addr_q.delete();
        exp_inst_q.delete();
    endtask

    task automatic push_refill(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] b;
        b = a & ~ADDR_W'(15);
        for (int k = 0; k < 16; k++) exp_addr_q.push_back(b + ADDR_W'(k));
    endtask

    // Called at posedge+#1; returns at posedge+#1 with the request dropped.
    task automatic fetch(input logic [ADDR_W-1:0] a);
        bit hit_pred;
        bit got;
        int cyc;
        hit_pred = m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
        if (!hit_pred) begin
            push_refill(a);
            m_valid[m_idx(a)] = 1'b1;
            m_tag[m_idx(a)]   = m_tagof(a);
        end
        exp_inst_q.push_back(model_word(a));
        acc_cnt = 0;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = a;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            if (bus.if_valid_o) got = 1'b1;
            else cyc++;
        end
        @(posedge clk);
        #1;
        bus.if_req_i = 1'b0;
        if (!got) begin
            fail_event("fetch_timeout", 32'(a));
            exp_addr_q.delete();
            exp_inst_q.delete();
        end else if (gap_mode == 0 && rdy_mode == 0) begin
            check("latency", 32'(cyc), hit_pred ? 32'd0 : 32'd18);
        end
        check("refill_bytes_left", 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic wait_bytes(input int n);
        int guard;
        guard = 0;
        while (acc_cnt < n && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (acc_cnt < n) fail_event("byte_wait_timeout", 32'(acc_cnt));
    endtask

    // Memory controller model.
    always @(posedge clk) begin
        #1;
        tog = ~tog;
        case (gap_mode)
            0:       bus.mem_valid_i = 1'b1;
            1:       bus.mem_valid_i = tog;
            default: bus.mem_valid_i = 1'($urandom_range(0, 1));
        endcase
        bus.mem_data_i = mem_img[bus.mem_addr_o];
    end

    // Global ready generator.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) begin
            bus.rdy = ($urandom_range(0, 3) != 0);
        end else if (stall_left > 0) begin
            bus.rdy = 1'b0;
            stall_left--;
        end else if (stall_trig >= 0 && acc_cnt >= stall_trig) begin
            bus.rdy    = 1'b0;
            stall_left = 2;
            stall_trig = -1;
        end else begin
            bus.rdy = 1'b1;
        end
    end

    // Monitor: compares every DUT output event against the scoreboard queues.
    logic              prev_req  = 1'b0;
    logic              prev_rdy  = 1'b1;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.if_valid_o) begin
                if (exp_inst_q.size() == 0) fail_event("unexpected_hit", 32'(bus.if_addr_i));
                else check("inst", bus.if_inst_o, exp_inst_q.pop_front());
            end
            if (bus.mem_req_o && bus.mem_valid_i && bus.rdy && !bus.flush_i) begin
                if (exp_addr_q.size() == 0) fail_event("unexpected_refill", 32'(bus.mem_addr_o));
                else check("mem_addr", 32'(bus.mem_addr_o), 32'(exp_addr_q.pop_front()));
                acc_cnt++;
            end
            if (!bus.rdy) check("valid_in_stall", 32'(bus.if_valid_o), 32'd0);
            if (prev_req && !prev_rdy && bus.mem_req_o)
                check("addr_hold", 32'(bus.mem_addr_o), 32'(prev_addr));
            prev_req  = bus.mem_req_o;
            prev_rdy  = bus.rdy;
            prev_addr = bus.mem_addr_o;
        end else begin
            prev_req = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem_img[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) mem_img[32'h40 + i] = 8'(i);
        model_invalidate();
        bus.rdy = 1'b1;
        bus.flush_i = 1'b0;
        bus.if_req_i = 1'b1;
        bus.if_addr_i = 18'h00040;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i = 8'h00;

        // Reset state, with a request pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_valid", 32'(bus.if_valid_o), 32'd0);
        check("rst_if_inst", bus.if_inst_o, 32'd0);
        check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.if_req_i = 1'b0;
        @(negedge clk);
        check("idle_mem_req", 32'(bus.mem_req_o), 32'd0);
        @(posedge clk);
        #1;

        // Basic fill of 0x00040 and word select.
        fetch(18'h00040);
        fetch(18'h00044);
        fetch(18'h0004B);
        fetch(18'h0004C);

        // Conflict on the same index with a different tag.
        fetch(18'h00440);
        fetch(18'h00040);
        fetch(18'h00440);

        // Gapped bytes with a 3-cycle stall mid-refill.
        gap_mode = 1;
        rdy_mode = 1;
        acc_cnt = 0;
        stall_trig = 5;
        fetch(18'h00044);
        gap_mode = 0;
        rdy_mode = 0;
        fetch(18'h00040);
        fetch(18'h00048);
        fetch(18'h0004C);

        // Flush at the 8th byte of a refill.
        fetch(18'h00100);
        fetch(18'h00104);
        push_refill(18'h00800);
        acc_cnt = 0;
        bus.if_req_i = 1'b1;
        bus.if_addr_i = 18'h00800;
        wait_bytes(7);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        bus.if_req_i = 1'b0;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        model_invalidate();
        @(negedge clk);
        check("flush_mem_req", 32'(bus.mem_req_o), 32'd0);
        @(posedge clk);
        #1;
        fetch(18'h00800);
        fetch(18'h00100);

        // Randomised traffic with random byte gaps and random ready.
        gap_mode = 2;
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            fetch(ADDR_W'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4)
                          | $urandom_range(0, 15)));
        end
        gap_mode = 0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a refill.
        push_refill(18'h00900);
        acc_cnt = 0;
        bus.if_req_i = 1'b1;
        bus.if_addr_i = 18'h00900;
        wait_bytes(4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.if_req_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("rstmid_if_valid", 32'(bus.if_valid_o), 32'd0);
        check("rstmid_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_invalidate();
        fetch(18'h00040);
        fetch(18'h00044);
        fetch(18'h00048);
        fetch(18'h0004C);
        fetch(18'h00040);

`ifdef ICACHE_STATS_EN
        check("stats_miss", miss_cnt, 32'd1);
        check("stats_hit", hit_cnt, 32'd5);
        @(negedge clk);
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt_q;
        @(posedge clk);
        #1;
        fetch(18'h00044);
        check("stats_hit_wrap", hit_cnt, 32'd0);
        check("stats_miss_hold", miss_cnt, 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
